// File: rtl/iecdrv_pkg.sv
// Shared types and constants for the IEC drive subsystem.
package iecdrv_pkg;

    localparam int unsigned IECDRV_MAX_DRIVES = 4;
    localparam int unsigned IECDRV_IDX_W      = 2;
    localparam int unsigned SD_TMO_W          = 24;

    typedef logic [31:0] sd_lba_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } sd_arb_state_t;

endpackage

// File: rtl/iecdrv_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping at NUM_REQ.
module iecdrv_rr_pick
    import iecdrv_pkg::*;
#(
    parameter int unsigned NUM_REQ = IECDRV_MAX_DRIVES
) (
    input  logic [IECDRV_MAX_DRIVES-1:0] req,
    input  logic [IECDRV_IDX_W-1:0]      last,
    output logic [IECDRV_IDX_W-1:0]      next_idx,
    output logic                         valid
);

    logic [IECDRV_IDX_W-1:0] cand;

    // Scan offsets 1..NUM_REQ from last; candidates never reach unused request bits.
    always_comb begin
        next_idx = '0;
        valid    = 1'b0;
        cand     = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IECDRV_IDX_W'((32'(last) + off) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid    = 1'b1;
                next_idx = cand;
            end
        end
    end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// Round-robin arbiter sharing the host SD sector channel among IEC drive instances.
module iecdrv_sd_arbiter
    import iecdrv_pkg::*;
#(
    parameter int unsigned         NUM_DRIVES = 4,
    parameter logic [SD_TMO_W-1:0] TIMEOUT    = 24'd16_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_DRIVES-1:0][31:0]      drv_lba,
    input  logic [NUM_DRIVES-1:0]            drv_rd,
    input  logic [NUM_DRIVES-1:0]            drv_wr,
    output logic [NUM_DRIVES-1:0]            drv_ack,
    input  logic [NUM_DRIVES-1:0][7:0]       drv_buff_din,
    output logic [NUM_DRIVES-1:0]            drv_buff_wr,
    output logic [31:0]                      sd_lba,
    output logic                             sd_rd,
    output logic                             sd_wr,
    input  logic                             sd_ack,
    input  logic                             sd_buff_wr,
    output logic [7:0]                       sd_buff_din,
    output logic                             busy,
    output logic [IECDRV_IDX_W-1:0]          grant,
    output logic                             timeout_err
);

    sd_arb_state_t               state_q, state_d;
    logic [IECDRV_IDX_W-1:0]     last_q, last_d;
    logic [IECDRV_IDX_W-1:0]     grant_q, grant_d;
    sd_lba_t                     sd_lba_q, sd_lba_d;
    logic                        sd_rd_q, sd_rd_d;
    logic                        sd_wr_q, sd_wr_d;
    logic                        busy_q, busy_d;
    logic                        timeout_err_q, timeout_err_d;
    logic [SD_TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [SD_TMO_W-1:0]         tmo_cnt_inc;

    // Requests and payloads widened to the maximum drive count; absent drives read as zero.
    logic [IECDRV_MAX_DRIVES-1:0]       rd_pad, wr_pad, req_pad;
    logic [IECDRV_MAX_DRIVES-1:0][31:0] lba_pad;
    logic [IECDRV_MAX_DRIVES-1:0][7:0]  din_pad;
    logic [IECDRV_MAX_DRIVES-1:0]       ack_pad, bwr_pad;

    logic [IECDRV_IDX_W-1:0] pick_idx;
    logic                    pick_valid;

    for (genvar i = 0; i < IECDRV_MAX_DRIVES; i++) begin : g_pad
        if (i < NUM_DRIVES) begin : g_used
            assign rd_pad[i]  = drv_rd[i];
            assign wr_pad[i]  = drv_wr[i];
            assign lba_pad[i] = drv_lba[i];
            assign din_pad[i] = drv_buff_din[i];
        end else begin : g_unused
            assign rd_pad[i]  = 1'b0;
            assign wr_pad[i]  = 1'b0;
            assign lba_pad[i] = '0;
            assign din_pad[i] = '0;
        end
    end

    assign req_pad = rd_pad | wr_pad;

    iecdrv_rr_pick #(
        .NUM_REQ (NUM_DRIVES)
    ) u_pick (
        .req      (req_pad),
        .last     (last_q),
        .next_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Next-state and registered output logic.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_d       = grant_q;
        sd_lba_d      = sd_lba_q;
        sd_rd_d       = sd_rd_q;
        sd_wr_d       = sd_wr_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = 1'b0;
        tmo_cnt_inc   = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + SD_TMO_W'(1);

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d   = pick_idx;
                    sd_lba_d  = lba_pad[pick_idx];
                    sd_rd_d   = rd_pad[pick_idx];
                    sd_wr_d   = ~rd_pad[pick_idx];
                    tmo_cnt_d = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = XFER;
                end else begin
                    tmo_cnt_d = tmo_cnt_inc;
                    if ((TIMEOUT != '0) && (tmo_cnt_inc >= TIMEOUT)) begin
                        sd_rd_d       = 1'b0;
                        sd_wr_d       = 1'b0;
                        timeout_err_d = 1'b1;
                        state_d       = RELEASE;
                    end
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= IECDRV_IDX_W'(NUM_DRIVES - 1);
            grant_q       <= '0;
            sd_lba_q      <= '0;
            sd_rd_q       <= 1'b0;
            sd_wr_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            grant_q       <= grant_d;
            sd_lba_q      <= sd_lba_d;
            sd_rd_q       <= sd_rd_d;
            sd_wr_q       <= sd_wr_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    // Zero-latency routing of ack, strobe and write data to the granted drive only.
    always_comb begin
        ack_pad     = '0;
        bwr_pad     = '0;
        sd_buff_din = 8'h00;
        if ((state_q == REQ) || (state_q == XFER)) begin
            ack_pad[grant_q] = sd_ack;
            bwr_pad[grant_q] = sd_buff_wr & sd_ack;
            sd_buff_din      = din_pad[grant_q];
        end
    end

    assign drv_ack     = ack_pad[NUM_DRIVES-1:0];
    assign drv_buff_wr = bwr_pad[NUM_DRIVES-1:0];
    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign busy        = busy_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule
